// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 codes, FSM state
// encodings, error cause encoding and the request legality check used at
// acceptance time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_RD      = 3'd1;
  localparam state_t S_RD_WAIT = 3'd2;
  localparam state_t S_WR      = 3'd3;
  localparam state_t S_RESP    = 3'd4;
  localparam state_t S_ERR     = 3'd5;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_FUNCT3   = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_RANGE    = 2'd3
  } err_cause_e;

  // Checks are ordered by priority: funct3 legality, then alignment, then
  // range. Store encodings above sw are illegal; loads only allow 0/1/2/4/5.
  function automatic err_cause_e check_req(input logic        we,
                                           input logic [2:0]  f3,
                                           input logic [31:0] addr,
                                           input int unsigned aw);
    logic legal;
    logic misalign;
    logic out_of_range;
    if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    misalign = (((f3 == F3_H) || (f3 == F3_HU)) && addr[0]) ||
               ((f3 == F3_W) && (addr[1:0] != 2'b00));
    out_of_range = (addr >> (aw + 2)) != 32'd0;
    if (!legal)            return CAUSE_FUNCT3;
    else if (misalign)     return CAUSE_MISALIGN;
    else if (out_of_range) return CAUSE_RANGE;
    else                   return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
//   word_i      : word read from memory
//   wdata_i     : store data (low byte/half used for sb/sh)
//   offset_i    : byte offset within the word (addr[1:0])
//   funct3_i    : RV32 funct3 of the access
//   load_data_o : selected byte/half/word, sign or zero extended
//   store_word_o: word_i with the store byte/half merged in at offset_i
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*offset_i +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      F3_W:    load_data_o = word_i;
      default: load_data_o = 32'd0;
    endcase
  end

  always_comb begin
    store_word_o = word_i;
    case (funct3_i)
      F3_B: store_word_o[8*offset_i +: 8] = wdata_i[7:0];
      F3_H: begin
        if (offset_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else             store_word_o[15:0]  = wdata_i[15:0];
      end
      F3_W:    store_word_o = wdata_i;
      default: store_word_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and the word-addressed data
// memory. Takes one byte-addressed RV32 load/store per handshake, turns it
// into word reads/writes (read-modify-write for sb/sh) and returns extended
// load data. Illegal, misaligned or out-of-range requests complete with
// resp_err and never touch memory.
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake
//   req_we/req_funct3/req_addr/req_wdata : request fields
//   resp_valid/resp_err/resp_rdata       : one-cycle completion
//   mem_addr/mem_rd_en/mem_wr_en/mem_wdata/mem_rdata : data memory port
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state_q, state_d;
  logic [31:0] mem_addr_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  err_cause_e  cause;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign cause     = check_req(req_we, req_funct3, req_addr, AW);

  lsu_align u_align (
    .word_i       (mem_rdata),
    .wdata_i      (wdata_q),
    .offset_i     (off_q),
    .funct3_i     (f3_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cause != CAUSE_NONE)                 state_d = S_ERR;
          else if (req_we && req_funct3 == F3_W)   state_d = S_WR;
          else                                     state_d = S_RD;
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = we_q ? S_WR : S_RESP;
      S_WR:      state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_addr_q <= 32'd0;
      off_q      <= 2'd0;
      f3_q       <= 3'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mem_addr_q <= {{(30-AW){1'b0}}, req_addr[AW+1:2]};
        off_q      <= req_addr[1:0];
        f3_q       <= req_funct3;
        we_q       <= req_we;
        wdata_q    <= req_wdata;
        rdata_q    <= 32'd0;
      end
      // RMW reuses wdata_q as the merged write word; loads keep the result.
      if (state_q == S_RD_WAIT) begin
        if (we_q) wdata_q <= store_word;
        else      rdata_q <= load_data;
      end
    end
  end

  assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
  assign resp_err   = (state_q == S_ERR);
  assign resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = wdata_q;
  // Gated by rst so a reset landing mid-RMW can never commit a write.
  assign mem_rd_en  = (state_q == S_RD) && !rst;
  assign mem_wr_en  = (state_q == S_WR) && !rst;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [256];
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0, acc_cnt = 0, bad_addr = 0;
  logic [7:0] last_rd_idx = 8'd0, last_wr_idx = 8'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory model: registered read, write commits on the strobe edge.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata   <= mem[mem_addr[7:0]];
      last_rd_idx <= mem_addr[7:0];
      rd_cnt      <= rd_cnt + 1;
    end
    if (mem_wr_en) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      last_wr_idx        <= mem_addr[7:0];
      wr_cnt             <= wr_cnt + 1;
    end
    if ((mem_rd_en || mem_wr_en) && mem_addr[31:8] != 24'd0) bad_addr <= bad_addr + 1;
    if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic err);
    bit got;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 0; lat = 0; rdata = 32'hDEADBEEF; err = 1'bx;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1; lat = k; rdata = resp_rdata; err = resp_err;
      end
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp);
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, f3, addr, 32'd0, lat, rd, err);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic err_case(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    int lat, r0, w0; logic [31:0] rd; logic err;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(we, f3, addr, 32'hFFFFFFFF, lat, rd, err);
    @(negedge clk);
    chk({tag, "_err"}, {31'd0, err}, 32'd1);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_rdata"}, rd, 32'd0);
    chk({tag, "_nomem"}, rd_cnt - r0 + wr_cnt - w0, 0);
  endtask

  initial begin
    int lat, r0, w0, n_resp, n_ready, a0, p0;
    int pos [3];
    logic [31:0] rd; logic err;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[2] = 32'h149A746A;
    mem[3] = 32'h0107B906;
    mem_rdata = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    load("lb_9",   3'd0, 32'h9, 32'h00000074);
    load("lb_D",   3'd0, 32'hD, 32'hFFFFFFB9);
    load("lbu_D",  3'd4, 32'hD, 32'h000000B9);
    load("lh_C",   3'd1, 32'hC, 32'hFFFFB906);
    load("lhu_A",  3'd5, 32'hA, 32'h0000149A);
    load("lw_8",   3'd2, 32'h8, 32'h149A746A);

    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 3'd2, 32'h20, 32'h11223344, lat, rd, err);
    chk("sw_lat", lat, 2);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_reads", rd_cnt - r0, 0);
    chk("sw_word", mem[8], 32'h11223344);

    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 3'd0, 32'h21, 32'hFFFFFFAB, lat, rd, err);
    chk("sb_lat", lat, 4);
    chk("sb_rdata", rd, 32'd0);
    chk("sb_err", {31'd0, err}, 32'd0);
    chk("sb_rw_cnt", {rd_cnt - r0, wr_cnt - w0}, {32'd1, 32'd1});
    chk("sb_idx", {last_rd_idx, last_wr_idx}, 32'h0808);
    chk("sb_word", mem[8], 32'h1122AB44);

    do_req(1'b1, 3'd1, 32'h22, 32'h0000BEEF, lat, rd, err);
    chk("sh_lat", lat, 4);
    chk("sh_word", mem[8], 32'hBEEFAB44);

    err_case("lw_A_mis",   1'b0, 3'd2, 32'hA);
    err_case("lh_3_mis",   1'b0, 3'd1, 32'h3);
    err_case("lw_400_oor", 1'b0, 3'd2, 32'h400);
    err_case("ld_f3_3",    1'b0, 3'd3, 32'h0);
    err_case("st_f3_4",    1'b1, 3'd4, 32'h20);
    chk("err_word8", mem[8], 32'hBEEFAB44);

    // Back-to-back lw with req_valid held high.
    @(negedge clk);
    a0 = acc_cnt; p0 = resp_cnt; n_resp = 0; n_ready = 0;
    for (int i = 0; i < 3; i++) pos[i] = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (acc_cnt - a0 >= 3) req_valid = 1'b0;
      if (k <= 11 && req_ready) n_ready++;
      if (resp_valid) begin
        if (n_resp < 3) pos[n_resp] = k;
        n_resp++;
        chk("b2b_rdata", resp_rdata, 32'h149A746A);
      end
    end
    chk("b2b_accepts", acc_cnt - a0, 3);
    chk("b2b_resps", n_resp, 3);
    chk("b2b_first", pos[0], 3);
    chk("b2b_gap1", pos[1] - pos[0], 4);
    chk("b2b_gap2", pos[2] - pos[1], 4);
    chk("b2b_ready_hi", n_ready, 2);

    // Reset during RD_WAIT of an sb.
    @(negedge clk);
    r0 = rd_cnt; w0 = wr_cnt; p0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_rd_en", {31'd0, mem_rd_en}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rstmid_no_wr", wr_cnt - w0, 0);
    chk("rstmid_no_resp", resp_cnt - p0, 0);
    chk("rstmid_word8", mem[8], 32'hBEEFAB44);

    chk("never_both_strobes", both_cnt, 0);
    chk("mem_addr_upper", bad_addr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side load/store initiator for the word-addressed data memory: 256 x 32-bit, word index addressing, separate read/write enables.
- Accepts one byte-addressed RV32 load/store per handshake and converts it to word accesses.
- Does byte/halfword extraction with sign or zero extension on loads; does read-modify-write for sb/sh on stores.
- Sits between the MEM pipeline stage and the data memory; flags misaligned and out-of-range accesses without touching memory.

Parameters:
- AW, 8, log2 of memory depth in words; valid byte addresses are 0 .. 2^(AW+2)-1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (load: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu; store: 0 sb, 1 sh, 2 sw)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes used for sb/sh
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; misaligned, illegal funct3 or out of range
- resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and errors
- mem_addr  out  32  word index = {0, req_addr[AW+1:2]}
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe; write commits on the edge where it is high
- mem_wdata  out  32  word to write
- mem_rdata  in  32  memory read data, valid the cycle after mem_rd_en

Behaviour:
- FSM states: IDLE, RD, RD_WAIT, WR, RESP, ERR.
- Request fields are latched on acceptance.
- req_ready = (state == IDLE) && !rst.
- Reset values: state IDLE; resp_valid 0, resp_err 0, resp_rdata 0; mem_rd_en 0, mem_wr_en 0; mem_addr 0, mem_wdata 0.
- Acceptance checks in IDLE, in priority order:
  - Illegal funct3 (load 3/6/7, store 3..7) -> ERR.
  - Misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) -> ERR.
  - Out of range (addr[31:AW+2] != 0) -> ERR.
  - Otherwise: load -> RD; sw -> WR with mem_wdata = req_wdata; sb/sh -> RD (RMW).
- RD: mem_rd_en=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: capture mem_rdata.
  - Load: select byte/half by addr[1:0] / addr[1], extend per funct3 -> RESP.
  - RMW: merge store byte/half into the captured word at the offset -> WR.
- WR: mem_wr_en=1 for exactly one cycle -> RESP.
- RESP: resp_valid=1, resp_err=0 -> IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0; no mem strobe ever issued -> IDLE.
- Latency, counted from the accepting edge to the resp_valid cycle: load 3 cycles, sw 2, sb/sh 4, error 1.
- One outstanding request only. req_ready stays low from acceptance through the RESP/ERR cycle. A new request can be accepted in the cycle after resp_valid.
- mem_rd_en and mem_wr_en are never high together.
- Reset mid-operation: the FSM returns to IDLE on the rst edge with no response pulse. mem_rd_en and mem_wr_en are gated by !rst, so a pending RMW never writes.
- Memory-mapped words (I/O mailbox at index 0/1, constants at 2..6) get no special treatment. All sub-word stores to them go through RMW.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum.
  - Error cause encoding.
- Sub-module lsu_align, purely combinational:
  - load_extract(word, offset, funct3) -> 32-bit result.
  - store_merge(old_word, wdata, offset, funct3) -> 32-bit word.
- mem_access_unit holds the FSM and registers.

Test Plan:
- Loads from preloaded words 2 = 0x149A746A and 3 = 0x0107B906:
  - lb 0x9 -> 0x00000074, 3 cycles.
  - lb 0xD -> 0xFFFFFFB9.
  - lbu 0xD -> 0x000000B9.
  - lh 0xC -> 0xFFFFB906.
  - lhu 0xA -> 0x0000149A.
  - lw 0x8 -> 0x149A746A.
- sw 0x20 wdata 0x11223344, then sb 0x21 wdata 0xFFFFFFAB:
  - RD, WR of index 8.
  - Word becomes 0x1122AB44.
  - sb latency 4.
  - resp_rdata 0.
- sh 0x22 wdata 0x0000BEEF on word 0x1122AB44 -> word becomes 0xBEEFAB44.
- Error cases, each giving resp_err=1 one cycle after acceptance with no mem_rd_en/mem_wr_en:
  - lw 0xA (misaligned).
  - lh 0x3 (misaligned).
  - lw 0x400 with AW=8 (out of range).
  - load funct3=3 (illegal).
- req_valid held high across three back-to-back lw:
  - Exactly three acceptances.
  - req_ready low during each busy window.
  - resp_valid pulses spaced 4 cycles apart.
- rst asserted during RD_WAIT of sb 0x21 wdata 0x55:
  - No mem_wr_en, no resp_valid.
  - Word 8 unchanged.
  - req_ready=1 in the first cycle after rst deasserts.
